// File: rtl/mult_pkg.sv
// Shared constants for the 32x32 signed multiplier datapath.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// LVL_ROWS[l] is the row count after CSA level l (LVL_ROWS[0] = input rows).
// Pipeline registers sit after every even level (2, 4, 6, 8).
package mult_pkg;

  localparam int W          = 64;
  localparam int N_PP       = 33;
  localparam int PIPE_DEPTH = 4;
  localparam int N_LVL      = 8;

  localparam int LVL_ROWS [0:N_LVL] = '{33, 22, 15, 10, 7, 5, 4, 3, 2};

  // Levels whose outputs are captured in a stage register bank.
  function automatic bit is_reg_level(input int l);
    return (l > 0) && (l % 2 == 0);
  endfunction

endpackage

// File: rtl/csa_3to2.sv
// 3:2 carry-save adder over W-bit rows; s + cy == a + b + c (mod 2^W).
// Latency: combinational.
// Backpressure: none.
//
// Ports: a, b, c  input rows
//        s        bitwise sum
//        cy       majority carries, already shifted left by 1 (top carry-out dropped)
module csa_3to2 #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] s,
  output logic [W-1:0] cy
);

  assign s  = a ^ b ^ c;
  assign cy = ((a & b) | (a & c) | (b & c)) << 1;

endmodule

// File: rtl/wallace_csa_pipe.sv
// Wallace-tree reduction of 33 partial-product rows to a sum/carry pair over 4 register stages.
// Latency: 4 cycles from accept to out_valid when unstalled; 1 result/cycle throughput.
// Backpressure: global stall; all stages hold while out_valid & ~out_ready, in_ready follows.
//
// Ports: clk, rst_n          clock, async active-low reset
//        pp_flat, in_valid   row k = pp_flat[64*k +: 64]; in_ready = stage 1 can load
//        sum_o, carry_o      reduced rows (carry already shifted); out_valid/out_ready handshake
// Only W = 64 and N_PP = 33 are supported: the level schedule in mult_pkg is fixed for them.
module wallace_csa_pipe
  import mult_pkg::*;
#(
  parameter int W    = mult_pkg::W,
  parameter int N_PP = mult_pkg::N_PP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W*N_PP-1:0] pp_flat,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [W-1:0]      sum_o,
  output logic [W-1:0]      carry_o,
  output logic              out_valid,
  input  logic              out_ready
);

  // node[l][i]: combinational row i produced by level l (node[0] = unpacked input rows).
  // lvl_in[l][i]: row i feeding level l, either a level output or a stage register.
  // Only the first LVL_ROWS[] entries of each level are used.
  logic [W-1:0] node   [0:N_LVL][0:N_PP-1];
  logic [W-1:0] lvl_in [1:N_LVL][0:N_PP-1];

  // Stage register banks, sized by the row count after levels 2, 4, 6, 8.
  logic [W-1:0] s1 [0:LVL_ROWS[2]-1];
  logic [W-1:0] s2 [0:LVL_ROWS[4]-1];
  logic [W-1:0] s3 [0:LVL_ROWS[6]-1];
  logic [W-1:0] s4 [0:LVL_ROWS[8]-1];

  logic [PIPE_DEPTH-1:0] vld;   // vld[0] = S1 ... vld[PIPE_DEPTH-1] = S4
  logic                  advance;

  for (genvar k = 0; k < N_PP; k++) begin : g_in
    assign node[0][k] = pp_flat[W*k +: W];
  end

  for (genvar l = 1; l <= N_LVL; l++) begin : g_lvl
    localparam int NI = LVL_ROWS[l-1];
    localparam int NT = NI / 3;

    // A level directly after a register bank reads the bank, otherwise the previous level.
    for (genvar i = 0; i < NI; i++) begin : g_src
      if (l == 3) begin : g_s1
        assign lvl_in[l][i] = s1[i];
      end else if (l == 5) begin : g_s2
        assign lvl_in[l][i] = s2[i];
      end else if (l == 7) begin : g_s3
        assign lvl_in[l][i] = s3[i];
      end else begin : g_comb
        assign lvl_in[l][i] = node[l-1][i];
      end
    end

    // Triples in ascending index order; outputs interleave s, cy per triple.
    for (genvar t = 0; t < NT; t++) begin : g_csa
      csa_3to2 #(.W(W)) u_csa (
        .a  (lvl_in[l][3*t]),
        .b  (lvl_in[l][3*t+1]),
        .c  (lvl_in[l][3*t+2]),
        .s  (node[l][2*t]),
        .cy (node[l][2*t+1])
      );
    end

    // One or two leftover rows ride through unchanged after the CSA outputs.
    for (genvar j = 0; j < NI - 3*NT; j++) begin : g_pass
      assign node[l][2*NT+j] = lvl_in[l][3*NT+j];
    end
  end

  // Bubbles are not collapsed: the whole pipe moves or the whole pipe holds.
  assign advance   = ~vld[PIPE_DEPTH-1] | out_ready;
  assign in_ready  = advance;
  assign out_valid = vld[PIPE_DEPTH-1];
  assign sum_o     = s4[0];
  assign carry_o   = s4[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < LVL_ROWS[2]; i++) s1[i] <= '0;
      for (int i = 0; i < LVL_ROWS[4]; i++) s2[i] <= '0;
      for (int i = 0; i < LVL_ROWS[6]; i++) s3[i] <= '0;
      for (int i = 0; i < LVL_ROWS[8]; i++) s4[i] <= '0;
    end else if (advance) begin
      // Data banks load unconditionally; contents behind a clear valid bit are don't-care.
      vld <= {vld[PIPE_DEPTH-2:0], in_valid};
      for (int i = 0; i < LVL_ROWS[2]; i++) s1[i] <= node[2][i];
      for (int i = 0; i < LVL_ROWS[4]; i++) s2[i] <= node[4][i];
      for (int i = 0; i < LVL_ROWS[6]; i++) s3[i] <= node[6][i];
      for (int i = 0; i < LVL_ROWS[8]; i++) s4[i] <= node[8][i];
    end
  end

endmodule
